// File: rtl/step_pulse_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : step_pulse_conditioner_if
//  Description : Bus between the per-axis stepper PIO register block and the
//                step pulse conditioner.
//                master : drives pio_in / pos_clear / overrun_clr and observes
//                         the driver pins, position and status.
//                slave  : the conditioner itself.
//  Ports       : pio_in[2:0]  PIO levels {enable, direction, step request}
//                pos_clear    one-cycle synchronous clear of position
//                overrun_clr  one-cycle synchronous clear of overrun
//                step_out     driver STEP pin
//                dir_out      driver DIR pin
//                en_n_out     driver ENABLE pin, active low
//                position     signed step count (two's complement)
//                overrun      sticky dropped-request flag
//                busy         pulse in flight or request pending
//  Revision    : 1.0 - initial release
// ============================================================================
interface step_pulse_conditioner_if #(
    parameter int POS_W = 32
);
    logic [2:0]       pio_in;
    logic             pos_clear;
    logic             overrun_clr;
    logic             step_out;
    logic             dir_out;
    logic             en_n_out;
    logic [POS_W-1:0] position;
    logic             overrun;
    logic             busy;

    modport master (
        output pio_in, pos_clear, overrun_clr,
        input  step_out, dir_out, en_n_out, position, overrun, busy
    );

    modport slave (
        input  pio_in, pos_clear, overrun_clr,
        output step_out, dir_out, en_n_out, position, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/step_pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : step_pulse_conditioner
//  Description : Converts software-toggled PIO step/dir/enable levels into
//                stepper-driver-legal timing: direction setup before each
//                step edge, minimum step high and low widths, a one-deep
//                request queue with sticky overrun, and a signed position
//                counter.
//  Ports       : clk      system clock
//                reset_n  asynchronous active-low reset
//                bus      step_pulse_conditioner_if.slave (see interface)
//  Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_conditioner #(
    parameter int DIR_SETUP_CYC  = 10,
    parameter int PULSE_HIGH_CYC = 100,
    parameter int PULSE_LOW_CYC  = 100,
    parameter int CNT_W          = 16,
    parameter int POS_W          = 32
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    step_pulse_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIR_SETUP = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_t;

    // Timers count down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] C_DIR_LOAD  = CNT_W'(DIR_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_HIGH_LOAD = CNT_W'(PULSE_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] C_LOW_LOAD  = CNT_W'(PULSE_LOW_CYC - 1);
    localparam logic [POS_W-1:0] C_POS_ONE   = POS_W'(1);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic             step_prev_q, step_prev_d;
    logic             pending_q,   pending_d;
    logic             step_out_q,  step_out_d;
    logic             dir_out_q,   dir_out_d;
    logic             en_n_out_q,  en_n_out_d;
    logic [POS_W-1:0] position_q,  position_d;
    logic             overrun_q,   overrun_d;
    logic             busy_q,      busy_d;

    logic w_enable;
    logic w_req;
    logic w_enter_high;
    logic w_drop;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        dir_out_d    = dir_out_q;
        position_d   = position_q;
        overrun_d    = overrun_q;
        w_enter_high = 1'b0;
        w_drop       = 1'b0;

        w_enable    = bus.pio_in[2];
        // Edges seen while disabled are discarded outright.
        w_req       = bus.pio_in[0] & ~step_prev_q & w_enable;
        step_prev_d = bus.pio_in[0];
        en_n_out_d  = ~w_enable;

        case (state_q)
            ST_IDLE: begin
                if (w_req || (pending_q && w_enable)) begin
                    pending_d = 1'b0;
                    if (bus.pio_in[1] != dir_out_q) begin
                        dir_out_d = bus.pio_in[1];
                        state_d   = ST_DIR_SETUP;
                        timer_d   = C_DIR_LOAD;
                    end else begin
                        state_d      = ST_HIGH;
                        timer_d      = C_HIGH_LOAD;
                        w_enter_high = 1'b1;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (timer_q == '0) begin
                    state_d      = ST_HIGH;
                    timer_d      = C_HIGH_LOAD;
                    w_enter_high = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_HIGH: begin
                if (timer_q == '0) begin
                    state_d = ST_LOW;
                    timer_d = C_LOW_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin // ST_LOW
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
        endcase

        // One-deep queue for requests arriving mid-pulse.
        if (state_q != ST_IDLE && w_req) begin
            if (pending_q) begin
                w_drop = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
        if (!w_enable) begin
            pending_d = 1'b0;
        end

        // dir_out_d is already the direction the pulse will carry.
        if (w_enter_high) begin
            position_d = dir_out_d ? position_q + C_POS_ONE
                                   : position_q - C_POS_ONE;
        end
        if (bus.pos_clear) begin
            position_d = '0;
        end

        // A new overrun wins over a simultaneous clear.
        if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (w_drop) begin
            overrun_d = 1'b1;
        end

        step_out_d = (state_d == ST_HIGH);
        busy_d     = (state_d != ST_IDLE) | pending_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            step_prev_q <= 1'b1;
            pending_q   <= 1'b0;
            step_out_q  <= 1'b0;
            dir_out_q   <= 1'b0;
            en_n_out_q  <= 1'b1;
            position_q  <= '0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            step_prev_q <= step_prev_d;
            pending_q   <= pending_d;
            step_out_q  <= step_out_d;
            dir_out_q   <= dir_out_d;
            en_n_out_q  <= en_n_out_d;
            position_q  <= position_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.step_out = step_out_q;
    assign bus.dir_out  = dir_out_q;
    assign bus.en_n_out = en_n_out_q;
    assign bus.position = position_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = busy_q;

endmodule
`default_nettype wire
